// File: rtl/dining_table_arb.sv
// rtl/dining_table_arb.sv - round-robin fork arbiter for N_PHILO dining philosophers
// Seats move IDLE -> WAIT -> EAT -> IDLE; forks are always taken in pairs so the table cannot deadlock.
module dining_table_arb #(
    parameter int N_PHILO = 5,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PHILO-1:0]         hungry_evt,
    input  logic [N_PHILO-1:0]         done_evt,
    output logic [N_PHILO-1:0]         eat_evt,
    output logic [N_PHILO-1:0]         fork_used,
    output logic [N_PHILO-1:0]         eating,
    output logic [N_PHILO-1:0]         waiting,
    output logic [N_PHILO*CNT_W-1:0]   meals,
    output logic                       proto_err
);

    localparam int RR_W = (N_PHILO > 1) ? $clog2(N_PHILO) : 1;

    logic [N_PHILO-1:0]       waiting_r, eating_r, eat_evt_r;
    logic [N_PHILO*CNT_W-1:0] meals_r;
    logic [RR_W-1:0]          rr, rr_next;
    logic                     err_r;

    logic [N_PHILO-1:0] fork_busy, grant, taken;
    logic [N_PHILO-1:0] hungry_ok, done_ok, err_vec;
    logic               found;
    int                 idx, nxt;

    // Fork k is held by seat k (its left fork) or by seat k-1 (its right fork).
    always_comb begin
        fork_busy = '0;
        for (int k = 0; k < N_PHILO; k++) begin
            fork_busy[k] = eating_r[k] | eating_r[(k + N_PHILO - 1) % N_PHILO];
        end
    end

    // Illegal events are dropped entirely; a hungry+done collision drops both.
    always_comb begin
        hungry_ok = hungry_evt & ~waiting_r & ~eating_r & ~done_evt;
        done_ok   = done_evt & eating_r & ~hungry_evt;
        err_vec   = (hungry_evt & (waiting_r | eating_r | done_evt))
                  | (done_evt & (~eating_r | hungry_evt));
    end

    // Round-robin scan from rr; earlier grants in the scan claim their forks first.
    always_comb begin
        grant   = '0;
        taken   = '0;
        rr_next = rr;
        found   = 1'b0;
        idx     = 0;
        nxt     = 0;
        for (int k = 0; k < N_PHILO; k++) begin
            idx = (int'(rr) + k) % N_PHILO;
            nxt = (idx + 1) % N_PHILO;
            if (waiting_r[idx] && !fork_busy[idx] && !taken[idx]
                && !fork_busy[nxt] && !taken[nxt]) begin
                grant[idx] = 1'b1;
                taken[idx] = 1'b1;
                taken[nxt] = 1'b1;
                if (!found) begin
                    found   = 1'b1;
                    rr_next = RR_W'(nxt);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            waiting_r <= '0;
            eating_r  <= '0;
            eat_evt_r <= '0;
            meals_r   <= '0;
            rr        <= '0;
            err_r     <= 1'b0;
        end else begin
            waiting_r <= (waiting_r & ~grant) | hungry_ok;
            eating_r  <= (eating_r & ~done_ok) | grant;
            eat_evt_r <= grant;
            rr        <= rr_next;
            err_r     <= err_r | (|err_vec);
            for (int i = 0; i < N_PHILO; i++) begin
                if (grant[i]) begin
                    meals_r[i*CNT_W +: CNT_W] <= meals_r[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign eat_evt   = eat_evt_r;
    assign fork_used = fork_busy;
    assign eating    = eating_r;
    assign waiting   = waiting_r;
    assign meals     = meals_r;
    assign proto_err = err_r;

endmodule

// File: tb/tb_dining_table_arb.sv
// tb/tb_dining_table_arb.sv - directed self-checking bench for dining_table_arb
module tb_dining_table_arb;

    localparam int N = 5;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    hungry_evt, done_evt;
    logic [N-1:0]    eat_evt, fork_used, eating, waiting;
    logic [N*CW-1:0] meals;
    logic            proto_err;

    int total = 0;
    int bad   = 0;

    dining_table_arb #(.N_PHILO(N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .hungry_evt(hungry_evt), .done_evt(done_evt),
        .eat_evt(eat_evt), .fork_used(fork_used),
        .eating(eating), .waiting(waiting),
        .meals(meals), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of events, then return inputs to quiet.
    task automatic step(input logic [N-1:0] h, input logic [N-1:0] d);
        hungry_evt = h;
        done_evt   = d;
        tick();
        hungry_evt = '0;
        done_evt   = '0;
    endtask

    function automatic logic [CW-1:0] meal(input int i);
        logic [N*CW-1:0] m;
        m = meals;
        return m[i*CW +: CW];
    endfunction

    always @(negedge clk) begin
        chk("inv_adjacent", 128'(eating & {eating[0], eating[N-1:1]}), 128'd0);
        chk("inv_forks", 128'($countones(fork_used)), 128'(2 * $countones(eating)));
        chk("inv_evt_sub", 128'(eat_evt & ~eating), 128'd0);
        chk("inv_wait_eat", 128'(waiting & eating), 128'd0);
    end

    initial begin
        reset      = 1'b0;
        hungry_evt = '0;
        done_evt   = '0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("idle_eat_evt", 128'(eat_evt), 128'd0);
        chk("idle_fork", 128'(fork_used), 128'd0);
        chk("idle_eating", 128'(eating), 128'd0);
        chk("idle_waiting", 128'(waiting), 128'd0);
        chk("idle_meals", 128'(meals), 128'd0);
        chk("idle_err", 128'(proto_err), 128'd0);

        // Single request on seat 0
        step(5'b00001, 5'b00000);
        chk("single_wait", 128'(waiting), 128'b00001);
        chk("single_no_evt", 128'(eat_evt), 128'd0);
        tick();
        chk("single_evt", 128'(eat_evt), 128'b00001);
        chk("single_fork", 128'(fork_used), 128'b00011);
        chk("single_meal0", 128'(meal(0)), 128'd1);
        chk("single_wait_clr", 128'(waiting), 128'd0);
        tick();
        chk("single_evt_pulse", 128'(eat_evt), 128'd0);
        step(5'b00000, 5'b00001);
        chk("single_release", 128'(fork_used), 128'd0);
        chk("single_eating_clr", 128'(eating), 128'd0);

        // Seat 4 alone brings rr back to 0 (wraps across the table)
        step(5'b10000, 5'b00000);
        tick();
        chk("wrap_evt", 128'(eat_evt), 128'b10000);
        chk("wrap_fork", 128'(fork_used), 128'b10001);
        step(5'b00000, 5'b10000);

        // Neighbour contention with rr=0
        step(5'b00011, 5'b00000);
        tick();
        chk("cont_evt", 128'(eat_evt), 128'b00001);
        chk("cont_wait", 128'(waiting), 128'b00010);
        chk("cont_fork", 128'(fork_used), 128'b00011);
        step(5'b00000, 5'b00001);
        chk("cont_freed", 128'(fork_used), 128'd0);
        chk("cont_no_reuse", 128'(eat_evt), 128'd0);
        tick();
        chk("cont_evt1", 128'(eat_evt), 128'b00010);
        chk("cont_fork1", 128'(fork_used), 128'b00110);
        chk("cont_meal0", 128'(meal(0)), 128'd2);
        chk("cont_meal1", 128'(meal(1)), 128'd1);
        step(5'b00000, 5'b00010);

        // Maximal parallelism from a clean reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        step(5'b11111, 5'b00000);
        chk("par_wait_all", 128'(waiting), 128'b11111);
        tick();
        chk("par_evt", 128'(eat_evt), 128'b00101);
        chk("par_fork", 128'(fork_used), 128'b01111);
        chk("par_wait", 128'(waiting), 128'b11010);
        tick();
        chk("par_blocked", 128'(eat_evt), 128'd0);
        step(5'b00000, 5'b00101);
        tick();
        chk("par_evt2", 128'(eat_evt), 128'b01010);
        chk("par_fork2", 128'(fork_used), 128'b11110);
        chk("par_wait2", 128'(waiting), 128'b10000);
        step(5'b00000, 5'b01010);
        tick();
        chk("par_evt3", 128'(eat_evt), 128'b10000);
        chk("par_fork3", 128'(fork_used), 128'b10001);
        step(5'b00000, 5'b10000);
        chk("par_meals", 128'(meals), 128'({5{16'd1}}));
        chk("par_err", 128'(proto_err), 128'd0);

        // Protocol errors
        step(5'b00000, 5'b01000);
        chk("err_done_idle", 128'(proto_err), 128'd1);
        chk("err_done_state", 128'(eating | waiting), 128'd0);
        chk("err_done_meals", 128'(meals), 128'({5{16'd1}}));
        step(5'b00001, 5'b00000);
        tick();
        chk("err_eat0", 128'(eating), 128'b00001);
        step(5'b00001, 5'b00000);
        chk("err_hungry_wait", 128'(waiting), 128'd0);
        chk("err_hungry_eat", 128'(eating), 128'b00001);
        chk("err_sticky", 128'(proto_err), 128'd1);
        chk("err_meal0", 128'(meal(0)), 128'd2);

        // Reset mid-operation
        step(5'b10100, 5'b00000);
        tick();
        chk("mid_eating", 128'(eating), 128'b00101);
        chk("mid_waiting", 128'(waiting), 128'b10000);
        reset = 1'b0;
        tick();
        chk("mid_rst_eating", 128'(eating), 128'd0);
        chk("mid_rst_waiting", 128'(waiting), 128'd0);
        chk("mid_rst_fork", 128'(fork_used), 128'd0);
        chk("mid_rst_meals", 128'(meals), 128'd0);
        chk("mid_rst_err", 128'(proto_err), 128'd0);
        reset = 1'b1;
        step(5'b10000, 5'b00000);
        tick();
        chk("mid_evt4", 128'(eat_evt), 128'b10000);
        chk("mid_fork4", 128'(fork_used), 128'b10001);
        chk("mid_meal4", 128'(meal(4)), 128'd1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dining_table_arb.md
Name: dining_table_arb

Overview:
- Parametrised fork arbiter for the dining-philosophers demo. Generalises the fixed two-philosopher table to N_PHILO seats.
- Collects HUNGRY and DONE event pulses from the philo instances and allocates forks without deadlock, using round-robin fairness.
- Returns one-cycle EAT event pulses to the philo instances.
- Exposes fork and seat status for LEDs and debug.

Parameters:
- N_PHILO, 5, number of philosophers and forks; legal range 2..32. Philosopher i uses fork i (left) and fork (i+1) mod N_PHILO (right).
- CNT_W, 16, width of the per-seat meal counters.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- hungry_evt  in  N_PHILO  bit i is a one-cycle pulse: philosopher i requests both forks.
- done_evt  in  N_PHILO  bit i is a one-cycle pulse: philosopher i finished eating and releases its forks.
- eat_evt  out  N_PHILO  bit i is a one-cycle pulse: forks granted, philosopher i may eat.
- fork_used  out  N_PHILO  bit k is high while fork k is held.
- eating  out  N_PHILO  bit i is high from grant until done is sampled.
- waiting  out  N_PHILO  bit i is high while the request is latched and not yet granted.
- meals  out  N_PHILO*CNT_W  packed per-seat grant counters; seat i occupies bits [i*CNT_W +: CNT_W].
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset==0 at an edge): all outputs and internal state go to 0, and the round-robin pointer rr goes to 0. While reset is low, input events are ignored.
- Seat state per philosopher: IDLE -> WAIT -> EAT -> IDLE. Outputs map as WAIT = waiting[i], EAT = eating[i].
- hungry_evt[i] sampled at edge E0 in IDLE: waiting[i]=1 after E0.
- Grant evaluation at each edge uses the registered state only:
  - Scan seats in order rr, rr+1, ..., rr+N_PHILO-1 (mod N_PHILO).
  - Grant seat j if waiting[j] is high and both of its forks are free.
  - A fork counts as free only if it is not in fork_used and was not taken by an earlier grant in the same scan.
  - Several non-adjacent seats may be granted in one cycle.
- On a grant to seat j, after that edge:
  - waiting[j]=0, eating[j]=1.
  - Both forks of seat j set in fork_used.
  - eat_evt[j]=1 for exactly one cycle.
  - meals[j] increments, wrapping modulo 2^CNT_W.
- Minimum latency: hungry sampled at E0 -> eat_evt high after E1.
- rr update: if any grant occurred, rr <= (highest-priority granted seat + 1) mod N_PHILO. Otherwise rr is unchanged.
- done_evt[i] sampled at edge E while eating[i]: after E, eating[i]=0 and both forks are cleared. The freed forks are first grantable at E+1; there is no same-edge reuse.
- The same edge may carry a done for one seat, a new hungry for another seat, and grants. All three apply independently. A hungry sampled at E can be granted no earlier than E+1.
- Protocol errors set proto_err=1, which stays set until reset; the offending event is ignored and state is unchanged:
  - hungry_evt[i] while waiting[i] or eating[i];
  - done_evt[i] while not eating[i];
  - hungry_evt[i] and done_evt[i] in the same cycle.
- Invariants the bench checks every cycle:
  - Adjacent seats are never both eating.
  - popcount(fork_used) == 2*popcount(eating).
  - eat_evt is a subset of eating.
  - waiting & eating == 0.
- No deadlock: forks are taken atomically in pairs. No starvation: a waiting seat is granted within N_PHILO grant rounds once its neighbours cycle through.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no events for 10 cycles -> all outputs 0, proto_err=0.
- Single request (N=5): hungry_evt=5'b00001 at E0 -> waiting[0]=1 after E0; after E1: eat_evt=5'b00001 (one cycle), fork_used=5'b00011, meals[0]=1. done_evt[0] then clears fork_used to 0.
- Neighbour contention: hungry on seats 0 and 1 at the same edge with rr=0 -> seat 0 granted, seat 1 stays waiting, rr=1. done_evt[0] at E -> seat 1 granted at E+1 with fork_used=5'b00110.
- Maximal parallelism: all five seats hungry at once, rr=0 -> seats 0 and 2 granted together (eat_evt=5'b00101, fork_used=5'b01111), rr=1. As they finish, all five seats eventually eat exactly once with no adjacent-eating violation.
- Protocol errors: done_evt[3] while idle -> proto_err=1 and no other state change. hungry_evt[0] while eating[0] -> ignored, proto_err stays 1.
- Reset mid-operation: reset=0 while seats 0 and 2 are eating and seat 4 is waiting -> after the edge all state is 0. A new hungry_evt[4] then grants normally two edges later.
